// File: rtl/cordic_iter_ctrl.sv
// Iteration sequencer for a single-stage feedback CORDIC datapath.
// Runs LOAD -> ITERS micro-rotations -> DONE and drives the mux select, enable, shift and direction.
module cordic_iter_ctrl #(
  parameter int ITERS = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic             z_neg,
  input  logic             y_neg,
  output logic             busy,
  output logic             done,
  output logic             load_sel,
  output logic             reg_en,
  output logic [CNT_W-1:0] shift_amt,
  output logic [CNT_W-1:0] atan_addr,
  output logic             dir
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_DONE
  } state_t;

  // Terminal count is compared in CNT_W bits so ITERS == 2**CNT_W ends on all-ones.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          mode_d  = mode;
        end
      end
      S_LOAD: begin
        state_d = S_ITER;
        cnt_d   = '0;
      end
      S_ITER: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    load_sel  = 1'b0;
    reg_en    = 1'b0;
    shift_amt = '0;
    atan_addr = '0;
    dir       = 1'b0;
    case (state_q)
      S_LOAD: begin
        busy   = 1'b1;
        reg_en = 1'b1;
      end
      S_ITER: begin
        busy      = 1'b1;
        reg_en    = 1'b1;
        load_sel  = 1'b1;
        shift_amt = cnt_q;
        atan_addr = cnt_q;
        dir       = mode_q ? y_neg : ~z_neg;
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        load_sel = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/cordic_iter_ctrl.md
Name: cordic_iter_ctrl

Overview:
- Sequencer for the iterative (single-stage, feedback) CORDIC datapath.
- Drives the select of the x/y/z register-input bus muxes (0 = initial operands, 1 = shifted/added feedback) and the register enable.
- Supplies the per-iteration shift amount and arctangent table address, and the add/subtract direction.
- Performs a start/busy/done handshake with the host logic.

Parameters:
- ITERS, 16, number of micro-rotations per operation; legal range 1..2**CNT_W.
- CNT_W, 4, width of the iteration counter, shift_amt and atan_addr.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- mode  input  1  0 = rotation (direction from z sign), 1 = vectoring (direction from y sign); latched at start.
- z_neg  input  1  sign bit of current z register, from datapath.
- y_neg  input  1  sign bit of current y register, from datapath.
- busy  output  1  high from LOAD through DONE inclusive.
- done  output  1  one-cycle pulse; results valid in datapath registers.
- load_sel  output  1  bus mux select: 0 = data0 (initial operands), 1 = data1 (feedback).
- reg_en  output  1  x/y/z register load enable.
- shift_amt  output  CNT_W  current iteration index i (shift by i).
- atan_addr  output  CNT_W  arctangent ROM address, equal to shift_amt.
- dir  output  1  1 = x-=y>>i, y+=x>>i, z-=atan(i); 0 = opposite signs.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset, and has priority over everything.
- Reset values: state = IDLE, cnt = 0, mode_q = 0. Outputs: busy = 0, done = 0, load_sel = 0, reg_en = 0, shift_amt = 0, atan_addr = 0, dir = 0.
- Output style: Moore outputs decoded from registered state and cnt. dir is the only output combinational from inputs, and it is gated to 0 outside ITER.
- IDLE:
  - All outputs at reset values.
  - start = 1 at an edge -> LOAD; mode is latched into mode_q at that edge.
- LOAD (1 cycle):
  - busy = 1, reg_en = 1, load_sel = 0, so registers capture the initial operands.
  - Next edge -> ITER with cnt = 0.
- ITER (ITERS cycles):
  - busy = 1, reg_en = 1, load_sel = 1, shift_amt = atan_addr = cnt.
  - dir = ~z_neg when mode_q = 0; dir = y_neg when mode_q = 1.
  - Each edge: if cnt == ITERS-1 -> DONE and cnt = 0; else cnt = cnt + 1.
- DONE (1 cycle):
  - busy = 1, done = 1, reg_en = 0, load_sel = 1, shift_amt = 0.
  - Next edge -> IDLE.
- Latency: start sampled at edge k gives done high in the cycle after edge k+ITERS+1, and busy low again after edge k+ITERS+2.
  - Back-to-back operation: start held high re-enters LOAD at edge k+ITERS+3.
- start outside IDLE is ignored and is not queued.
- mode and input changes during an operation are ignored, except z_neg and y_neg, which are live per iteration.
- ITERS = 1: ITER lasts exactly one cycle with shift_amt = 0.
- ITERS = 2**CNT_W: the terminal compare is on cnt == ITERS-1 (all ones); the counter must never wrap to 0 while in ITER.
- Reset asserted mid-operation (any state): next edge forces IDLE with all outputs at reset values.
  - No done pulse is produced; register contents are don't-care.
- reset and start high together: reset wins and the FSM stays in IDLE.

Test Plan:
- Reset then idle: reset high 2 cycles, start = 0 for 5 cycles -> busy = done = reg_en = load_sel = 0, shift_amt = 0 every cycle.
- Nominal rotation, ITERS = 16, mode = 0: pulse start at edge 0.
  - Required: LOAD cycle after edge 0 shows load_sel = 0, reg_en = 1.
  - Required: 16 ITER cycles show shift_amt = 0,1,...,15 with load_sel = 1.
  - Required: done = 1 for exactly one cycle after edge 17; busy = 0 after edge 18.
- Direction decode: in rotation drive z_neg = 0,1,0 on iterations 0..2 -> dir = 1,0,1.
  - Repeat with mode = 1 and y_neg = 1,0,0 -> dir = 1,0,0.
  - Toggle z_neg during vectoring -> dir unaffected.
- start held high continuously: ops start at edges 0, 19, 38.
  - Required: no start is accepted while busy = 1; exactly one done per 19 cycles.
- Mid-op reset: assert reset while shift_amt = 7 -> next cycle all outputs 0 and state IDLE, no done pulse.
  - Then a new start gives shift_amt sequence restarting at 0.
- Boundary configuration ITERS = 1 and ITERS = 16 with CNT_W = 4 -> ITER length 1 and 16 cycles respectively, no counter wrap, done pulse exactly once.
